// File: rtl/mp_adder_pkg.sv
// mp_adder_pkg: FSM state type, chunk-count helpers and parameter legality check for mp_adder_seq
package mp_adder_pkg;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  function automatic int nchunk(input int aw, input int cw);
    return aw / cw;
  endfunction
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic bit legal(input int aw, input int cw);
    return cw > 0 && cw % 4 == 0 && aw >= cw && aw % cw == 0;
  endfunction
endpackage

// File: rtl/mp_adder_if.sv
// mp_adder_if: operand/result handshake bundle (iSub present only with MP_ADDER_SUB_EN)
interface mp_adder_if #(parameter int W = 256);
  logic iValid, oReady, iC, oValid, iReady, oC;
  logic [W-1:0] iA, iB, oSum;
`ifdef MP_ADDER_SUB_EN
  logic iSub;
  modport slave(input iValid, iA, iB, iC, iSub, iReady, output oReady, oValid, oSum, oC);
  modport master(output iValid, iA, iB, iC, iSub, iReady, input oReady, oValid, oSum, oC);
`else
  modport slave(input iValid, iA, iB, iC, iReady, output oReady, oValid, oSum, oC);
  modport master(output iValid, iA, iB, iC, iReady, input oReady, oValid, oSum, oC);
`endif
endinterface

// File: rtl/mp_chunk_adder.sv
// mp_chunk_adder: combinational W-bit adder built from rippled 4-bit carry-lookahead groups
module mp_chunk_adder #(parameter int W = 64) (
  input  logic [W-1:0] iA,
  input  logic [W-1:0] iB,
  input  logic         iC,
  output logic [W-1:0] oSum,
  output logic         oC
);
  logic [W-1:0] g, p;
  logic [W:0]   c;
  assign g = iA & iB;
  assign p = iA ^ iB;
  always_comb begin
    c = '0;
    c[0] = iC;
    for (int k = 0; k < W / 4; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
  end
  assign oSum = p ^ c[W-1:0];
  assign oC   = c[W];
endmodule

// File: rtl/mp_adder_seq.sv
// mp_adder_seq: chunk-serial multi-precision adder A+B+C (A-B when MP_ADDER_SUB_EN is defined)
module mp_adder_seq
  import mp_adder_pkg::*;
#(
  parameter int ADDER_WIDTH = 256,
  parameter int CHUNK_WIDTH = 64
) (
  input logic       iClk,
  input logic       iRst,
  mp_adder_if.slave bus
);
  localparam int N     = nchunk(ADDER_WIDTH, CHUNK_WIDTH);
  localparam int CNT_W = cnt_w(N);
  if (!legal(ADDER_WIDTH, CHUNK_WIDTH)) begin : g_bad
    $error("mp_adder_seq: ADDER_WIDTH must be a multiple of CHUNK_WIDTH, CHUNK_WIDTH a multiple of 4");
  end
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDER_WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, sum_sh, b_in;
  logic                   c_q, c_d, c_in, acc, add, last, co;
  logic [CHUNK_WIDTH-1:0] cs;
  mp_chunk_adder #(.W(CHUNK_WIDTH)) u_chunk (
    .iA  (a_q[CHUNK_WIDTH-1:0]),
    .iB  (b_q[CHUNK_WIDTH-1:0]),
    .iC  (c_q),
    .oSum(cs),
    .oC  (co)
  );
  if (N == 1) begin : g_one
    assign sum_sh = cs;
  end else begin : g_many
    assign sum_sh = {cs, sum_q[ADDER_WIDTH-1:CHUNK_WIDTH]};
  end
`ifdef MP_ADDER_SUB_EN
  assign b_in = bus.iSub ? ~bus.iB : bus.iB;
  assign c_in = bus.iSub | bus.iC;
`else
  assign b_in = bus.iB;
  assign c_in = bus.iC;
`endif
  always_comb begin
    acc     = state_q == IDLE && bus.iValid;
    add     = state_q == ADD;
    last    = cnt_q == CNT_W'(N - 1);
    state_d = acc ? ADD : (add && last) ? DONE : (state_q == DONE && bus.iReady) ? IDLE : state_q;
    cnt_d   = acc ? '0 : add ? cnt_q + 1'b1 : cnt_q;
    a_d     = acc ? bus.iA : add ? a_q >> CHUNK_WIDTH : a_q;
    b_d     = acc ? b_in : add ? b_q >> CHUNK_WIDTH : b_q;
    c_d     = acc ? c_in : add ? co : c_q;
    sum_d   = add ? sum_sh : sum_q;
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
    end
  end
  assign bus.oReady = state_q == IDLE;
  assign bus.oValid = state_q == DONE;
  assign bus.oSum   = sum_q;
  assign bus.oC     = c_q;
endmodule

// File: tb/tb_mp_adder_seq.sv
// tb_mp_adder_seq: random and directed checks of mp_adder_seq against a transaction-level model
module tb_mp_adder_seq;
  localparam int AW = 256;
  localparam int NCHUNK = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  mp_adder_if #(.W(AW)) bus();
  mp_adder_seq #(.ADDER_WIDTH(AW), .CHUNK_WIDTH(64)) dut (.iClk(clk), .iRst(rst), .bus(bus));
  always #5 clk = ~clk;
  bit          en = 0;
  bit          m_valid = 0;
  int          m_wait = 0;
  logic [AW:0] m_res = '0;
  task automatic chk(input string name, input logic [AW:0] act, input logic [AW:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      en = 1;
      m_valid = 0;
      m_wait = 0;
    end else if (m_valid) begin
      if (bus.iReady) m_valid = 0;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) m_valid = 1;
    end else if (bus.iValid) begin
      m_res = {1'b0, bus.iA} + {1'b0, bus.iB} + {{AW{1'b0}}, bus.iC};
`ifdef MP_ADDER_SUB_EN
      if (bus.iSub) m_res = {1'b0, bus.iA} + {1'b0, ~bus.iB} + 1;
`endif
      m_wait = NCHUNK;
    end
  end
  always @(negedge clk) begin
    if (en) begin
      chk("ready", bus.oReady, !m_valid && m_wait == 0);
      chk("valid", bus.oValid, m_valid);
      if (m_valid) chk("result", {bus.oC, bus.oSum}, m_res);
    end
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic set_sub(input logic s);
`ifdef MP_ADDER_SUB_EN
    bus.iSub = s;
`else
    if (s) $display("sub requested without MP_ADDER_SUB_EN");
`endif
  endtask
  function automatic logic [AW-1:0] rnd();
    logic [AW-1:0] r;
    for (int i = 0; i < AW / 64; i++) begin
      case ($urandom % 4)
        0: r[64*i+:64] = '0;
        1: r[64*i+:64] = '1;
        default: r[64*i+:64] = {$urandom, $urandom};
      endcase
    end
    return r;
  endfunction
  task automatic launch(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic c, input logic s);
    int n;
    bus.iValid = 1; bus.iA = a; bus.iB = b; bus.iC = c; set_sub(s);
    step();
    bus.iValid = 0;
    n = 0;
    while (!bus.oValid && n < 20) begin
      step();
      n++;
    end
    chk("latency", n, NCHUNK);
  endtask
  initial begin
    bus.iValid = 0; bus.iReady = 1; bus.iA = '0; bus.iB = '0; bus.iC = 0; set_sub(0);
    step();
    step();
    rst = 0;
    chk("rst_ready", bus.oReady, 1);
    chk("rst_valid", bus.oValid, 0);
    chk("rst_sum", bus.oSum, 0);
    chk("rst_c", bus.oC, 0);
    launch(1, 1, 0, 0);
    chk("one_plus_one", {bus.oC, bus.oSum}, 2);
    step();
    launch('1, 1, 0, 0);
    chk("all_ones_plus_one", {bus.oC, bus.oSum}, {1'b1, {AW{1'b0}}});
    step();
    launch({{(AW-64){1'b0}}, {64{1'b1}}}, 0, 1, 0);
    chk("chunk_boundary", {bus.oC, bus.oSum}, {1'b0, {(AW-65){1'b0}}, 1'b1, 64'd0});
    step();
    bus.iReady = 0;
    launch(3, 4, 0, 0);
    for (int i = 0; i < 10; i++) begin
      bus.iValid = 1; bus.iA = rnd(); bus.iB = rnd(); bus.iC = 1;
      step();
      chk("hold_result", {bus.oC, bus.oSum}, 7);
      chk("hold_ready", bus.oReady, 0);
      chk("hold_valid", bus.oValid, 1);
    end
    bus.iValid = 0; bus.iReady = 1;
    step();
    chk("release_valid", bus.oValid, 0);
    chk("release_ready", bus.oReady, 1);
    bus.iValid = 1; bus.iA = 9; bus.iB = 9; bus.iC = 0;
    step();
    bus.iValid = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    chk("abort_ready", bus.oReady, 1);
    chk("abort_valid", bus.oValid, 0);
    launch(10, 20, 0, 0);
    chk("after_abort", {bus.oC, bus.oSum}, 30);
    step();
`ifdef MP_ADDER_SUB_EN
    launch(5, 7, 0, 1);
    chk("sub_borrow", {bus.oC, bus.oSum}, {1'b0, ~256'd1});
    step();
    launch(7, 5, 0, 1);
    chk("sub_no_borrow", {bus.oC, bus.oSum}, {1'b1, 256'd2});
    step();
`endif
    for (int i = 0; i < 400; i++) begin
      bus.iValid = ($urandom % 3) != 0;
      bus.iA = rnd(); bus.iB = rnd(); bus.iC = 1'($urandom);
      bus.iReady = 1'($urandom);
      set_sub(0);
`ifdef MP_ADDER_SUB_EN
      set_sub(1'($urandom));
`endif
      step();
    end
    bus.iValid = 0; bus.iReady = 1;
    for (int i = 0; i < 8; i++) step();
    chk("drained", bus.oReady, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
